// File: rtl/sipo_stream.sv
// Serial-in/parallel-out deserialiser with a ready/valid output register.
// Completed words that arrive while the output is still pending are dropped and flagged.
module sipo_stream #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0,
  parameter bit GAP_ABORT = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic                     s_in,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         p_out,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     overflow
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic             word_done;

  if (LSB_FIRST) begin : g_lsb_first
    assign sr_next = {s_in, sr[WIDTH-1:1]};
  end else begin : g_msb_first
    assign sr_next = {sr[WIDTH-2:0], s_in};
  end

  // The final bit of a word is only ever taken in SHIFT because WIDTH >= 2.
  assign word_done = (state == SHIFT) && in_valid && (bit_cnt == LAST_BIT);

  // NOTE: every register here is assigned with <= so all updates see the
  // pre-edge values; blocking assignments would make the handshake order-dependent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sr        <= '0;
      bit_cnt   <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      p_out     <= '0;
    end else if (clear) begin
      state     <= IDLE;
      sr        <= '0;
      bit_cnt   <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sr      <= sr_next;
            bit_cnt <= CW'(1);
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (in_valid) begin
            sr <= sr_next;
            if (word_done) begin
              bit_cnt <= '0;
              state   <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end else if (GAP_ABORT) begin
            sr      <= '0;
            bit_cnt <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // A word finishing while the previous one is stuck is lost, not queued.
      if (word_done) begin
        if (!out_valid || out_ready) begin
          p_out     <= sr_next;
          out_valid <= 1'b1;
        end else begin
          overflow  <= 1'b1;
        end
      end
    end
  end

endmodule
